// File: rtl/jstk_move_ctrl.sv
// Joystick move controller: qualifies a stable stick direction, issues a held move request to
// the board engine, and enforces return-to-neutral plus a cooldown between moves.
module jstk_move_ctrl #(
  parameter int unsigned STABLE_CYCLES   = 16,
  parameter int unsigned COOLDOWN_CYCLES = 50000,
  parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  dir_in,
  input  logic        enable,
  output logic        move_req,
  output logic [1:0]  move_dir,
  input  logic        move_ack,
  output logic        busy,
  output logic        timeout_err,
  output logic [15:0] move_count
);

  // Counters hold "samples already taken", so the current sample completes the run at N-1.
  localparam logic [15:0] StableLast = 16'(STABLE_CYCLES - 1);
  localparam logic [15:0] CoolLast   = 16'(COOLDOWN_CYCLES - 1);
  localparam logic [23:0] TmoLast    = 24'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StWaitCenter,
    StArmed,
    StQualify,
    StRequest,
    StCooldown
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [23:0] tmo_q, tmo_d;
  logic [1:0]  cand_q, cand_d;
  logic        req_q, req_d;
  logic [1:0]  dir_q, dir_d;
  logic        busy_q, busy_d;
  logic        terr_q, terr_d;
  logic [15:0] count_q, count_d;

  logic neutral;
  assign neutral = dir_in[2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    cand_d  = cand_q;
    req_d   = req_q;
    dir_d   = dir_q;
    busy_d  = busy_q;
    terr_d  = 1'b0;
    count_d = count_q;
    unique case (state_q)
      StWaitCenter: begin
        if (!neutral) begin
          cnt_d = '0;
        end else if (cnt_q == StableLast) begin
          state_d = StArmed;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StArmed: begin
        if (enable && !neutral) begin
          cand_d = dir_in[1:0];
          if (STABLE_CYCLES == 1) begin
            state_d = StRequest;
            req_d   = 1'b1;
            dir_d   = dir_in[1:0];
            busy_d  = 1'b1;
            tmo_d   = '0;
            cnt_d   = '0;
          end else begin
            state_d = StQualify;
            cnt_d   = 16'd1;
          end
        end
      end
      StQualify: begin
        if (!enable || neutral) begin
          state_d = StArmed;
          cnt_d   = '0;
        end else if (dir_in[1:0] != cand_q) begin
          cand_d = dir_in[1:0];
          cnt_d  = 16'd1;
        end else if (cnt_q == StableLast) begin
          state_d = StRequest;
          req_d   = 1'b1;
          dir_d   = cand_q;
          busy_d  = 1'b1;
          tmo_d   = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StRequest: begin
        // Ack is checked first so a same-cycle timeout never fires.
        if (move_ack) begin
          state_d = StCooldown;
          req_d   = 1'b0;
          count_d = count_q + 16'd1;
          cnt_d   = '0;
        end else if (tmo_q == TmoLast) begin
          state_d = StWaitCenter;
          req_d   = 1'b0;
          busy_d  = 1'b0;
          terr_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          tmo_d = tmo_q + 24'd1;
        end
      end
      StCooldown: begin
        if (cnt_q == CoolLast) begin
          state_d = StWaitCenter;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = StWaitCenter;
        req_d   = 1'b0;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StWaitCenter;
      cnt_q   <= '0;
      tmo_q   <= '0;
      cand_q  <= '0;
      req_q   <= 1'b0;
      dir_q   <= '0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      cand_q  <= cand_d;
      req_q   <= req_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      terr_q  <= terr_d;
      count_q <= count_d;
    end
  end

  assign move_req    = req_q;
  assign move_dir    = dir_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;
  assign move_count  = count_q;

endmodule

// File: tb/tb_jstk_move_ctrl.sv
// Directed bench for jstk_move_ctrl with STABLE=4, COOLDOWN=8, TIMEOUT=32.
module tb_jstk_move_ctrl;

  localparam int unsigned Stable   = 4;
  localparam int unsigned Cooldown = 8;
  localparam int unsigned Timeout  = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  dir_in;
  logic        enable;
  logic        move_req;
  logic [1:0]  move_dir;
  logic        move_ack;
  logic        busy;
  logic        timeout_err;
  logic [15:0] move_count;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_count = 16'd0;

  jstk_move_ctrl #(
    .STABLE_CYCLES  (Stable),
    .COOLDOWN_CYCLES(Cooldown),
    .TIMEOUT_CYCLES (Timeout)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .dir_in     (dir_in),
    .enable     (enable),
    .move_req   (move_req),
    .move_dir   (move_dir),
    .move_ack   (move_ack),
    .busy       (busy),
    .timeout_err(timeout_err),
    .move_count (move_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] d, input int n);
    dir_in = d;
    repeat (n) tick();
  endtask

  // Neutral long enough to clear any cooldown and qualify centre.
  task automatic go_armed;
    drive(3'b100, Stable + Cooldown + 2);
  endtask

  task automatic ack_once;
    move_ack = 1'b1;
    tick();
    move_ack = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    checks++; if (move_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", move_req); end
    checks++; if (move_dir !== 2'b00) begin errors++; $display("FAIL reset_dir: got %b want 00", move_dir); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_terr: got %b want 0", timeout_err); end
    checks++; if (move_count !== 16'h0000) begin errors++; $display("FAIL reset_count: got %h want 0000", move_count); end
  endtask

  task automatic test_basic_move;
    int n;
    drive(3'b100, Stable);
    drive(3'b010, Stable - 1);
    checks++; if (move_req !== 1'b0) begin errors++; $display("FAIL basic_early: got %b want 0", move_req); end
    tick();
    checks++; if (move_req !== 1'b1) begin errors++; $display("FAIL basic_req: got %b want 1", move_req); end
    checks++; if (move_dir !== 2'b10) begin errors++; $display("FAIL basic_dir: got %b want 10", move_dir); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_req: got %b want 1", busy); end
    dir_in = 3'b000;
    ack_once();
    exp_count = exp_count + 16'd1;
    checks++; if (move_req !== 1'b0) begin errors++; $display("FAIL basic_ack_req: got %b want 0", move_req); end
    checks++; if (move_count !== exp_count) begin errors++; $display("FAIL basic_count: got %h want %h", move_count, exp_count); end
    n = 0;
    for (int i = 0; i < 20 && busy; i++) begin n++; tick(); end
    checks++; if (n !== Cooldown) begin errors++; $display("FAIL basic_cooldown: got %0d want %0d", n, Cooldown); end
  endtask

  task automatic test_hold_no_repeat;
    int seen;
    seen = 0;
    for (int i = 0; i < 100; i++) begin tick(); if (move_req) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL hold_repeat: got %0d req cycles want 0", seen); end
    drive(3'b100, Stable);
    drive(3'b000, Stable);
    checks++; if (move_req !== 1'b1) begin errors++; $display("FAIL hold_req2: got %b want 1", move_req); end
    checks++; if (move_dir !== 2'b00) begin errors++; $display("FAIL hold_dir2: got %b want 00", move_dir); end
    dir_in = 3'b100;
    ack_once();
    exp_count = exp_count + 16'd1;
    checks++; if (move_count !== exp_count) begin errors++; $display("FAIL hold_count: got %h want %h", move_count, exp_count); end
  endtask

  task automatic test_recapture;
    int seen;
    go_armed();
    drive(3'b011, 3);
    drive(3'b001, 3);
    checks++; if (move_req !== 1'b0) begin errors++; $display("FAIL recap_early: got %b want 0", move_req); end
    tick();
    checks++; if (move_req !== 1'b1) begin errors++; $display("FAIL recap_req: got %b want 1", move_req); end
    checks++; if (move_dir !== 2'b01) begin errors++; $display("FAIL recap_dir: got %b want 01", move_dir); end
    dir_in = 3'b100;
    ack_once();
    exp_count = exp_count + 16'd1;
    go_armed();
    seen = 0;
    dir_in = 3'b010; tick(); if (move_req) seen++;
    tick(); if (move_req) seen++;
    dir_in = 3'b100; tick(); if (move_req) seen++;
    dir_in = 3'b010; tick(); if (move_req) seen++;
    tick(); if (move_req) seen++;
    dir_in = 3'b100; tick(); if (move_req) seen++;
    checks++; if (seen !== 0) begin errors++; $display("FAIL interrupted_req: got %0d req cycles want 0", seen); end
  endtask

  task automatic test_timeout;
    int n;
    int early;
    go_armed();
    drive(3'b010, Stable);
    n = 0;
    early = 0;
    for (int i = 0; i < 40 && move_req; i++) begin
      n++;
      if (timeout_err) early++;
      tick();
    end
    checks++; if (n !== Timeout) begin errors++; $display("FAIL tmo_len: got %0d want %0d", n, Timeout); end
    checks++; if (early !== 0) begin errors++; $display("FAIL tmo_early: got %0d want 0", early); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_pulse: got %b want 1", timeout_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy: got %b want 0", busy); end
    checks++; if (move_count !== exp_count) begin errors++; $display("FAIL tmo_count: got %h want %h", move_count, exp_count); end
    tick();
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_width: got %b want 0", timeout_err); end
    n = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (move_req) n++; end
    checks++; if (n !== 0) begin errors++; $display("FAIL tmo_wait_center: got %0d req cycles want 0", n); end
  endtask

  task automatic test_ack_at_timeout;
    go_armed();
    drive(3'b010, Stable);
    repeat (Timeout - 1) tick();
    checks++; if (move_req !== 1'b1) begin errors++; $display("FAIL last_cycle_req: got %b want 1", move_req); end
    ack_once();
    exp_count = exp_count + 16'd1;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL ack_vs_tmo: got %b want 0", timeout_err); end
    checks++; if (move_req !== 1'b0) begin errors++; $display("FAIL ack_vs_tmo_req: got %b want 0", move_req); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ack_vs_tmo_busy: got %b want 1", busy); end
    checks++; if (move_count !== exp_count) begin errors++; $display("FAIL ack_vs_tmo_count: got %h want %h", move_count, exp_count); end
  endtask

  task automatic test_enable;
    int seen;
    enable = 1'b0;
    go_armed();
    seen = 0;
    dir_in = 3'b011;
    for (int i = 0; i < 20; i++) begin tick(); if (move_req) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL enable_low: got %0d req cycles want 0", seen); end
    enable = 1'b1;
    repeat (Stable - 1) tick();
    checks++; if (move_req !== 1'b0) begin errors++; $display("FAIL enable_early: got %b want 0", move_req); end
    tick();
    checks++; if (move_req !== 1'b1) begin errors++; $display("FAIL enable_req: got %b want 1", move_req); end
    checks++; if (move_dir !== 2'b11) begin errors++; $display("FAIL enable_dir: got %b want 11", move_dir); end
    dir_in = 3'b100;
    ack_once();
    exp_count = exp_count + 16'd1;
    checks++; if (move_count !== exp_count) begin errors++; $display("FAIL enable_count: got %h want %h", move_count, exp_count); end
  endtask

  task automatic test_reset_mid_request;
    go_armed();
    drive(3'b010, Stable);
    checks++; if (move_req !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %b want 1", move_req); end
    rst = 1'b1;
    tick();
    checks++; if (move_req !== 1'b0) begin errors++; $display("FAIL rstmid_req: got %b want 0", move_req); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rstmid_terr: got %b want 0", timeout_err); end
    checks++; if (move_count !== 16'h0000) begin errors++; $display("FAIL rstmid_count: got %h want 0000", move_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    rst = 1'b0;
    exp_count = 16'h0000;
  endtask

  task automatic test_count_wrap;
    go_armed();
    force dut.count_q = 16'hFFFF;
    tick();
    release dut.count_q;
    drive(3'b010, Stable);
    dir_in = 3'b100;
    ack_once();
    checks++; if (move_count !== 16'h0000) begin errors++; $display("FAIL count_wrap: got %h want 0000", move_count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    dir_in   = 3'b100;
    enable   = 1'b1;
    move_ack = 1'b0;
    test_reset();
    test_basic_move();
    test_hold_no_repeat();
    test_recapture();
    test_timeout();
    test_ack_at_timeout();
    test_enable();
    test_reset_mid_request();
    test_count_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
